// File: rtl/softmax_vec_ram.sv
// softmax_vec_ram: multi-read-port vector memory for the softmax datapath.
// Each row holds NUM lanes of DWIDTH bits. The block provides NUM_RD pipelined
// read ports with fixed READ_LAT latency, one lane-masked write port, a
// sequential zero-fill engine and sticky out-of-range error flags.
//
// Ports:
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   clear          1-cycle pulse, starts (or restarts) a zero-fill sweep
//   busy           zero-fill sweep in progress
//   wr_en/wr_addr/wr_lane_en/wr_data   row write with per-lane enables
//   rd_en/rd_addr  per-port read requests (port p at slice p)
//   rd_data/rd_valid  per-port read results, READ_LAT cycles after request
//   wr_err/rd_err  sticky error flags, cleared by reset or sweep start
module softmax_vec_ram #(
  parameter int unsigned DWIDTH         = 16,
  parameter int unsigned NUM            = 4,
  parameter int unsigned AWIDTH         = 10,
  parameter int unsigned MEM_SIZE       = 1024,
  parameter int unsigned NUM_RD         = 3,
  parameter int unsigned READ_LAT       = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  output logic                           busy,
  input  logic                           wr_en,
  input  logic [AWIDTH-1:0]              wr_addr,
  input  logic [NUM-1:0]                 wr_lane_en,
  input  logic [DWIDTH*NUM-1:0]          wr_data,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*AWIDTH-1:0]       rd_addr,
  output logic [NUM_RD*DWIDTH*NUM-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid,
  output logic                           wr_err,
  output logic                           rd_err
);

  localparam int unsigned ROW_W = DWIDTH * NUM;
  localparam int unsigned IW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [AWIDTH:0]   ROW_LIMIT = (AWIDTH+1)'(MEM_SIZE);
  localparam logic [AWIDTH-1:0] LAST_ROW  = AWIDTH'(MEM_SIZE - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [ROW_W-1:0] mem [MEM_SIZE];

  logic [0:0]        state, state_nxt;
  logic [AWIDTH-1:0] row_cnt, row_cnt_nxt;
  logic              init_pend;
  logic              wr_err_nxt, rd_err_nxt;
  logic              enter_clear_c;
  logic              busy_c;
  logic              wr_oor_c;
  logic              wr_ok_c;
  logic [AWIDTH-1:0] sweep_row_c;
  logic [NUM_RD-1:0] rd_oor_c;
  logic [NUM_RD-1:0][ROW_W-1:0] rd_row_c;

  logic [NUM_RD-1:0]            pipe_vld [READ_LAT];
  logic [NUM_RD-1:0][ROW_W-1:0] pipe_dat [READ_LAT];

  assign busy_c      = (state == ST_CLEAR);
  assign busy        = busy_c;
  assign wr_oor_c    = ({1'b0, wr_addr} >= ROW_LIMIT);
  assign wr_ok_c     = wr_en && !busy_c && !wr_oor_c;
  // A clear during a sweep restarts it by zeroing row 0 in that same cycle.
  assign sweep_row_c = clear ? '0 : row_cnt;

  // Zero-fill FSM next state, row counter and sticky error flags
  always_comb begin
    state_nxt     = state;
    row_cnt_nxt   = row_cnt;
    enter_clear_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear || init_pend) begin
          state_nxt     = ST_CLEAR;
          row_cnt_nxt   = '0;
          enter_clear_c = 1'b1;
        end
      end
      ST_CLEAR: begin
        enter_clear_c = clear;
        if (sweep_row_c == LAST_ROW) begin
          state_nxt   = ST_IDLE;
          row_cnt_nxt = '0;
        end else begin
          row_cnt_nxt = sweep_row_c + AWIDTH'(1);
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        row_cnt_nxt = '0;
      end
    endcase
    // New errors win over the clear-on-sweep-entry.
    wr_err_nxt = (enter_clear_c ? 1'b0 : wr_err) | (wr_en && (busy_c || wr_oor_c));
    rd_err_nxt = (enter_clear_c ? 1'b0 : rd_err) | (|(rd_en & rd_oor_c));
  end

  // FSM and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      row_cnt   <= '0;
      init_pend <= 1'(CLEAR_ON_RESET);
      wr_err    <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_cnt_nxt;
      init_pend <= 1'b0;
      wr_err    <= wr_err_nxt;
      rd_err    <= rd_err_nxt;
    end
  end

  // Storage array: sweep writes whole rows, external writes are lane-masked
  always_ff @(posedge clk) begin
    if (busy_c) begin
      mem[IW'(sweep_row_c)] <= '0;
    end else if (wr_ok_c) begin
      for (int unsigned i = 0; i < NUM; i++) begin
        if (wr_lane_en[i]) begin
          mem[IW'(wr_addr)][i*DWIDTH +: DWIDTH] <= wr_data[i*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  // Per-port read row as seen in the request cycle (zero when busy or out of range)
  always_comb begin
    rd_oor_c = '0;
    rd_row_c = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_oor_c[p] = ({1'b0, rd_addr[p*AWIDTH +: AWIDTH]} >= ROW_LIMIT);
      if (!busy_c && !rd_oor_c[p]) begin
        rd_row_c[p] = mem[IW'(rd_addr[p*AWIDTH +: AWIDTH])];
        // Same-row write this cycle: forward the enabled lanes when asked to.
        if ((RDW_MODE == 1) && wr_ok_c && (wr_addr == rd_addr[p*AWIDTH +: AWIDTH])) begin
          for (int unsigned i = 0; i < NUM; i++) begin
            if (wr_lane_en[i]) begin
              rd_row_c[p][i*DWIDTH +: DWIDTH] = wr_data[i*DWIDTH +: DWIDTH];
            end
          end
        end
      end
    end
  end

  // Read pipeline; data stages load only on valid so outputs hold between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < READ_LAT; k++) begin
        pipe_vld[k] <= '0;
        pipe_dat[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_en;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          pipe_dat[0][p] <= rd_row_c[p];
        end
      end
      for (int unsigned k = 1; k < READ_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        for (int unsigned p = 0; p < NUM_RD; p++) begin
          if (pipe_vld[k-1][p]) begin
            pipe_dat[k][p] <= pipe_dat[k-1][p];
          end
        end
      end
    end
  end

  assign rd_valid = pipe_vld[READ_LAT-1];
  assign rd_data  = pipe_dat[READ_LAT-1];

endmodule
